// File: rtl/bcd_serial_subtractor.sv
// Digit-serial packed-BCD subtractor: diff = a - b - bin, least significant digit first,
// one digit per clock, with a start/busy/done handshake and an invalid-digit report.
module bcd_serial_subtractor #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   diff,
    output logic                  bout,
    output logic                  invalid
);

    localparam int W    = 4 * DIGITS;
    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t          state, state_next;
    logic [IDXW-1:0] idx, idx_next;
    logic [W-1:0]    a_sh, b_sh, a_sh_next, b_sh_next, diff_next;
    logic            brw, brw_next;
    logic            done_next, bout_next, invalid_next;
    logic [4:0]      t;
    logic [3:0]      d;
    logic            bad;

    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic r;
        r = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                r = 1'b1;
            end
        end
        return r;
    endfunction

    assign busy = (state == RUN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            a_sh    <= '0;
            b_sh    <= '0;
            brw     <= 1'b0;
            diff    <= '0;
            bout    <= 1'b0;
            invalid <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_next;
            idx     <= idx_next;
            a_sh    <= a_sh_next;
            b_sh    <= b_sh_next;
            brw     <= brw_next;
            diff    <= diff_next;
            bout    <= bout_next;
            invalid <= invalid_next;
            done    <= done_next;
        end
    end

    // Operands are shifted right each RUN cycle so the current digit is always the low nibble.
    always_comb begin
        state_next   = state;
        idx_next     = idx;
        a_sh_next    = a_sh;
        b_sh_next    = b_sh;
        brw_next     = brw;
        diff_next    = diff;
        bout_next    = bout;
        invalid_next = invalid;
        done_next    = 1'b0;

        bad = has_bad_digit(a) | has_bad_digit(b);
        t   = {1'b0, a_sh[3:0]} - {1'b0, b_sh[3:0]} - {4'b0000, brw};
        d   = t[4] ? (t[3:0] + 4'd10) : t[3:0];

        case (state)
            IDLE: begin
                if (start) begin
                    if (bad) begin
                        done_next    = 1'b1;
                        invalid_next = 1'b1;
                        diff_next    = '0;
                        bout_next    = 1'b0;
                    end else begin
                        a_sh_next    = a;
                        b_sh_next    = b;
                        brw_next     = bin;
                        diff_next    = '0;
                        bout_next    = 1'b0;
                        invalid_next = 1'b0;
                        idx_next     = '0;
                        state_next   = RUN;
                    end
                end
            end
            RUN: begin
                diff_next[4*idx +: 4] = d;
                brw_next  = t[4];
                a_sh_next = a_sh >> 4;
                b_sh_next = b_sh >> 4;
                if (idx == IDXW'(DIGITS - 1)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                    bout_next  = t[4];
                    idx_next   = '0;
                end else begin
                    idx_next = idx + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Self-checking bench for bcd_serial_subtractor: vector table (directed + random against a
// decimal-arithmetic model), plus reset-mid-operation and back-to-back sequences.
module tb_bcd_serial_subtractor;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;
    localparam int LIMIT  = DIGITS + 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         bin;
    logic         busy, done, bout, invalid;
    logic [W-1:0] diff;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] exp_diff;
        logic         exp_bout;
        logic         exp_inv;
    } vec_t;

    vec_t vecs[$];

    bcd_serial_subtractor #(.DIGITS(DIGITS)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .bin     (bin),
        .busy    (busy),
        .done    (done),
        .diff    (diff),
        .bout    (bout),
        .invalid (invalid)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: operands as decimal integers, plain subtraction, wrap modulo 10^DIGITS.
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                                  output logic [W-1:0] md, output logic mbo, output logic minv);
        longint av, bv, r, m;
        minv = 1'b0;
        av = 0;
        bv = 0;
        m  = 1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (ma[4*i +: 4] > 4'd9 || mb[4*i +: 4] > 4'd9) minv = 1'b1;
            av = av * 10 + longint'(ma[4*i +: 4]);
            bv = bv * 10 + longint'(mb[4*i +: 4]);
            m  = m * 10;
        end
        md  = '0;
        mbo = 1'b0;
        if (!minv) begin
            r = av - bv - longint'(mbin);
            if (r < 0) begin
                r   = r + m;
                mbo = 1'b1;
            end
            for (int i = 0; i < DIGITS; i++) begin
                md[4*i +: 4] = 4'(r % 10);
                r = r / 10;
            end
        end
    endfunction

    function automatic logic [W-1:0] rand_bcd(input bit allow_bad);
        logic [W-1:0] v;
        for (int i = 0; i < DIGITS; i++) begin
            if (allow_bad && $urandom_range(0, 15) == 0) v[4*i +: 4] = 4'($urandom_range(10, 15));
            else v[4*i +: 4] = 4'($urandom_range(0, 9));
        end
        return v;
    endfunction

    function automatic vec_t mk(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vbin,
                                input logic [W-1:0] vd, input logic vbo, input logic vinv);
        vec_t v;
        v.a = va; v.b = vb; v.bin = vbin;
        v.exp_diff = vd; v.exp_bout = vbo; v.exp_inv = vinv;
        return v;
    endfunction

    task automatic apply_stimulus(input vec_t v);
        int cyc;
        @(negedge clk);
        start = 1'b1; a = v.a; b = v.b; bin = v.bin;
        @(negedge clk);
        start = 1'b0;
        if (v.exp_inv) begin
            check_output("inv_busy", 64'(busy), 64'd0);
            check_output("inv_done", 64'(done), 64'd1);
        end else begin
            check_output("run_busy", 64'(busy), 64'd1);
            cyc = 0;
            while (!done && cyc < LIMIT) begin
                // Garbage operands and ignored starts while the operation runs.
                start = 1'b1; a = rand_bcd(1'b1); b = rand_bcd(1'b1); bin = 1'($urandom);
                @(negedge clk);
                cyc++;
            end
            start = 1'b0;
            check_output("latency", 64'(cyc), 64'(DIGITS));
        end
        check_output("diff", 64'(diff), 64'(v.exp_diff));
        check_output("bout", 64'(bout), 64'(v.exp_bout));
        check_output("invalid", 64'(invalid), 64'(v.exp_inv));
        check_output("busy_at_done", 64'(busy), 64'd0);
        @(negedge clk);
        check_output("done_pulse", 64'(done), 64'd0);
        check_output("diff_hold", 64'(diff), 64'(v.exp_diff));
    endtask

    initial begin
        logic [W-1:0] ra, rb, rd, d1, d2;
        logic         rbin, rbo, rinv, bo1, bo2;
        int           cyc;

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(negedge clk);
        check_output("rst_busy", 64'(busy), 64'd0);
        check_output("rst_done", 64'(done), 64'd0);
        check_output("rst_diff", 64'(diff), 64'd0);
        check_output("rst_bout", 64'(bout), 64'd0);
        check_output("rst_invalid", 64'(invalid), 64'd0);
        rst_n = 1'b1;

        vecs.push_back(mk(16'h0052, 16'h0017, 1'b0, 16'h0035, 1'b0, 1'b0));
        vecs.push_back(mk(16'h0012, 16'h0025, 1'b0, 16'h9987, 1'b1, 1'b0));
        vecs.push_back(mk(16'h1000, 16'h0000, 1'b1, 16'h0999, 1'b0, 1'b0));
        vecs.push_back(mk(16'h00A3, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1));
        vecs.push_back(mk(16'h0000, 16'h0000, 1'b1, 16'h9999, 1'b1, 1'b0));
        vecs.push_back(mk(16'h9999, 16'h9999, 1'b0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(16'h0000, 16'h9999, 1'b1, 16'h0000, 1'b1, 1'b0));
        vecs.push_back(mk(16'h1234, 16'h00F0, 1'b0, 16'h0000, 1'b0, 1'b1));
        vecs.push_back(mk(16'h5000, 16'h0001, 1'b0, 16'h4999, 1'b0, 1'b0));
        for (int i = 0; i < 24; i++) begin
            ra = rand_bcd(1'b1);
            rb = rand_bcd(1'b1);
            rbin = 1'($urandom);
            model(ra, rb, rbin, rd, rbo, rinv);
            vecs.push_back(mk(ra, rb, rbin, rd, rbo, rinv));
        end

        foreach (vecs[i]) apply_stimulus(vecs[i]);

        // Reset lands on the second RUN edge; no done may follow.
        @(negedge clk);
        start = 1'b1; a = 16'h0052; b = 16'h0017; bin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_output("mid_rst_busy", 64'(busy), 64'd0);
        check_output("mid_rst_done", 64'(done), 64'd0);
        check_output("mid_rst_diff", 64'(diff), 64'd0);
        check_output("mid_rst_bout", 64'(bout), 64'd0);
        check_output("mid_rst_invalid", 64'(invalid), 64'd0);
        for (int i = 0; i < DIGITS + 2; i++) begin
            @(negedge clk);
            check_output("mid_rst_no_done", 64'(done), 64'd0);
        end
        apply_stimulus(mk(16'h0012, 16'h0025, 1'b0, 16'h9987, 1'b1, 1'b0));

        // Back-to-back: start held high, second operands presented during the first run.
        for (int k = 0; k < 3; k++) begin
            ra = rand_bcd(1'b0); rb = rand_bcd(1'b0); rbin = 1'($urandom);
            model(ra, rb, rbin, d1, bo1, rinv);
            @(negedge clk);
            start = 1'b1; a = ra; b = rb; bin = rbin;
            ra = rand_bcd(1'b0); rb = rand_bcd(1'b0); rbin = 1'($urandom);
            model(ra, rb, rbin, d2, bo2, rinv);
            @(negedge clk);
            a = ra; b = rb; bin = rbin;
            cyc = 0;
            while (!done && cyc < LIMIT) begin
                @(negedge clk);
                cyc++;
            end
            check_output("b2b_lat1", 64'(cyc), 64'(DIGITS));
            check_output("b2b_diff1", 64'(diff), 64'(d1));
            check_output("b2b_bout1", 64'(bout), 64'(bo1));
            @(negedge clk);
            start = 1'b0;
            cyc = 1;
            check_output("b2b_accept", 64'(busy), 64'd1);
            while (!done && cyc < LIMIT) begin
                @(negedge clk);
                cyc++;
            end
            check_output("b2b_lat2", 64'(cyc), 64'(DIGITS + 1));
            check_output("b2b_diff2", 64'(diff), 64'(d2));
            check_output("b2b_bout2", 64'(bout), 64'(bo2));
            check_output("b2b_invalid", 64'(invalid), 64'd0);
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
